spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  SPI mode-0 (CPOL=0, CPHA=0) master; initiator counterpart to SPI_slave on the same 4-wire link.
//  Takes bytes over a valid/ready stream, frames each with chip-select, shifts MSB-first on MOSI.
//  Returns the byte captured on MISO with a one-cycle rx_valid pulse.
//  Sits in the clk domain and drives the board SPI pins (sclk/cs_n/mosi) toward a slave device.
// PARAMETERS
//  CLK_DIV   4  clk cycles per SCLK half-period; SCLK = clk/(2*CLK_DIV); legal >= 2
//  DATA_W    8  bits per transfer
//  CS_SETUP  2  clk cycles cs_n low before first SCLK rise (>= 1)
//  CS_HOLD   2  clk cycles after last SCLK fall before cs_n deasserts (>= 1)
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous, active-high reset
//  tx_data   in   DATA_W  byte to send
//  tx_valid  in   1       tx_data valid
//  tx_ready  out  1       master can accept a byte (state IDLE)
//  rx_data   out  DATA_W  byte received on MISO; held until next rx_valid
//  rx_valid  out  1       one-cycle pulse, rx_data new
//  busy      out  1       high whenever state != IDLE
//  sclk      out  1       SPI clock, idle low
//  cs_n      out  1       chip select, active low
//  mosi      out  1       master out
//  miso      in   1       master in (sampled directly; slave is synchronous to sclk)
// BEHAVIOUR
//  Reset (sync, next edge, overrides all): state=IDLE, cs_n=1, sclk=0, mosi=0, rx_valid=0,
//   rx_data=0, busy=0, tx_ready=1; a transfer in flight is abandoned, no rx_valid issued.
//  Handshake: accept when tx_valid & tx_ready; tx_data latched into shift reg that cycle.
//   tx_ready is combinational from state==IDLE; tx_data may change after acceptance.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
//   IDLE : cs_n=1, sclk=0. On accept -> SETUP; cs_n=0 and mosi=MSB from next cycle.
//   SETUP: count CS_SETUP cycles, then SHIFT with divider cleared.
//   SHIFT: divider counts 0..CLK_DIV-1; at terminal count sclk toggles.
//     Rise: sample miso into rx shift reg LSB, bit counter++.
//     Fall: shift tx reg, drive next bit on mosi (not after last bit).
//     After DATA_W-th fall (sclk back low): rx_data <= rx shift reg, rx_valid=1 that edge, -> HOLD.
//   HOLD : count CS_HOLD cycles with sclk=0, then cs_n=1, -> IDLE.
//  Frame: cs_n low for exactly CS_SETUP + 2*DATA_W*CLK_DIV + CS_HOLD cycles; cs_n high >= 1 cycle between frames.
//  Back-to-back: tx_valid held high -> next accept the first IDLE cycle after HOLD.
//  mosi held at last value in HOLD, forced 0 in IDLE. tx_valid ignored outside IDLE.
// CONFIGURATION
//  Macro SPI_MASTER_BURST_EN:
//   defined: extra input tx_last (1 bit, sampled with tx_data). After HOLD with tx_last=0 the FSM
//    returns to IDLE but keeps cs_n=0; next accept skips SETUP and enters SHIFT directly.
//    tx_last=1 deasserts cs_n normally. Reset still forces cs_n=1.
//   undefined: no tx_last port; every byte is its own cs_n frame as above.
// STRUCTURE
//  Package spi_pkg: typedef enum spi_state_t {IDLE,SETUP,SHIFT,HOLD}; SPI_DATA_W=8 default constant.
//  Sub-module spi_clk_gen: divider producing sclk plus one-cycle rise/fall strobes; enable,
//   clear on SHIFT entry, reset to sclk=0.
//  Top-level holds FSM, tx/rx shift registers, bit counter, setup/hold counters.
// TESTING (bench uses a mode-0 slave model; CLK_DIV=4, CS_SETUP=2, CS_HOLD=2, DATA_W=8)
//  Send 0xA5, slave returns 0x3C -> mosi 1,0,1,0,0,1,0,1 at 8 rises; rx_data=0x3C, one rx_valid pulse.
//  Frame timing -> cs_n low 68 cycles, 8 sclk periods of 8 cycles, first rise 6 cycles after cs_n fall.
//  tx_valid held high, bytes 0x01,0xFF -> two frames, cs_n high >= 1 cycle between, rx_valid twice.
//  rst pulse during bit 4 of 0x55 -> next edge cs_n=1, sclk=0, no rx_valid; next 0x81 transfers clean.
//  Idle check: tx_valid=0 for 100 cycles -> sclk=0, cs_n=1, mosi=0, tx_ready=1, busy=0.
//  BURST_EN: 0x11 (tx_last=0), 0x22 (tx_last=1) -> single cs_n low window, 16 rises, 2 rx_valid.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam int unsigned SPI_DATA_W = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: sclk toggles every CLK_DIV enabled cycles; rise/fall flag the edge that
// happens at the next clk edge.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q;
    logic             sclk_q;
    logic             terminal;

    assign terminal = en && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise     = terminal && !sclk_q;
    assign fall     = terminal && sclk_q;
    assign sclk     = sclk_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (en) begin
            if (terminal) begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per cs_n frame, MSB first.
// SPI_MASTER_BURST_EN adds tx_last so consecutive bytes can share one cs_n window.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned DATA_W   = SPI_DATA_W,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
`ifdef SPI_MASTER_BURST_EN
    ,
    input  logic              tx_last
`endif
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned CNT_W = $clog2(max_u(CS_SETUP, CS_HOLD) + 1);

    spi_state_t        state_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cs_n_q;
    logic              mosi_q;
    logic              rx_valid_q;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              in_shift;
`ifdef SPI_MASTER_BURST_EN
    logic              last_q;
`endif

    assign in_shift = (state_q == SHIFT);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (in_shift),
        .clr  (!in_shift),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
            last_q     <= 1'b1;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        tx_shift_q <= tx_data;
                        mosi_q     <= tx_data[DATA_W-1];
                        bit_cnt_q  <= '0;
                        cnt_q      <= '0;
                        cs_n_q     <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
                        last_q     <= tx_last;
                        // cs_n still low means we are mid-burst: setup time already paid
                        state_q    <= cs_n_q ? SETUP : SHIFT;
`else
                        state_q    <= SETUP;
`endif
                    end else begin
                        mosi_q <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[DATA_W-2:0], miso};
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                    end else if (sclk_fall) begin
                        if (bit_cnt_q == BIT_W'(DATA_W)) begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= HOLD;
                        end else begin
                            tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                            mosi_q     <= tx_shift_q[DATA_W-2];
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                        cnt_q   <= '0;
                        mosi_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef SPI_MASTER_BURST_EN
                        cs_n_q  <= last_q;
`else
                        cs_n_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a mode-0 slave model on miso.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
`ifdef SPI_MASTER_BURST_EN
    logic       tx_last;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_master #(
        .CLK_DIV  (4),
        .DATA_W   (8),
        .CS_SETUP (2),
        .CS_HOLD  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
`ifdef SPI_MASTER_BURST_EN
        ,
        .tx_last  (tx_last)
`endif
    );

    // Mode-0 slave: MSB on cs_n fall, next bit after each sclk fall, reload every 8 bits.
    logic [7:0] slv_tx = 8'h00;
    logic [7:0] slv_shift = 8'h00;
    int         slv_bits = 0;
    logic [7:0] mosi_cap = 8'h00;
    int         rise_cnt = 0;

    initial miso = 1'b0;

    always @(negedge cs_n) begin
        slv_shift = slv_tx;
        slv_bits  = 0;
        miso      = slv_tx[7];
    end

    always @(negedge sclk) begin
        if (!cs_n) begin
            slv_bits++;
            if (slv_bits == 8) begin
                slv_bits  = 0;
                slv_shift = slv_tx;
            end else begin
                slv_shift = slv_shift << 1;
            end
            miso = slv_shift[7];
        end
    end

    always @(posedge sclk) begin
        mosi_cap = {mosi_cap[6:0], mosi};
        rise_cnt++;
    end

    // Frame monitor, sampled on the falling clk edge.
    int   cyc = 0;
    int   cs_low = 0;
    int   cs_fall_cnt = 0;
    int   cs_fall_cyc = 0;
    int   first_rise_cyc = -1;
    int   last_rise_cyc = 0;
    int   rxv_cnt = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (prev_cs && !cs_n) begin
            cs_fall_cyc    = cyc;
            cs_fall_cnt++;
            first_rise_cyc = -1;
        end
        if (!cs_n) cs_low++;
        if (rx_valid) rxv_cnt++;
        if (sclk && !prev_sclk) begin
            if (first_rise_cyc < 0) first_rise_cyc = cyc;
            last_rise_cyc = cyc;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic clear_stats();
        cs_low      = 0;
        cs_fall_cnt = 0;
        rxv_cnt     = 0;
        rise_cnt    = 0;
        mosi_cap    = 8'h00;
    endtask

    task automatic wait_rxv(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx_valid) return;
        end
        timeout(tag);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready && cs_n) return;
        end
        timeout(tag);
    endtask

    initial begin
        int idle_ok_sclk;
        int idle_ok_cs;
        int idle_ok_mosi;
        int idle_ok_rdy;
        int idle_ok_busy;

        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
`ifdef SPI_MASTER_BURST_EN
        tx_last  = 1'b1;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);

        // Single frame 0xA5 out, 0x3C back
        clear_stats();
        slv_tx   = 8'h3C;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check("acc_cs_n", 32'(cs_n), 32'd0);
        check("acc_mosi_msb", 32'(mosi), 32'd1);
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_tx_ready", 32'(tx_ready), 32'd0);
        wait_rxv("a5_rx_valid_wait");
        check("a5_rx_data", 32'(rx_data), 32'h3C);
        wait_idle("a5_idle_wait");
        repeat (3) @(negedge clk);
        check("a5_mosi_bits", 32'(mosi_cap), 32'hA5);
        check("a5_rises", 32'(rise_cnt), 32'd8);
        check("a5_rx_pulses", 32'(rxv_cnt), 32'd1);
        check("a5_cs_low_cycles", 32'(cs_low), 32'd68);
        check("a5_first_rise_delay", 32'(first_rise_cyc - cs_fall_cyc), 32'd6);
        check("a5_rise_span", 32'(last_rise_cyc - first_rise_cyc), 32'd56);
        check("a5_rx_data_held", 32'(rx_data), 32'h3C);
        check("a5_mosi_idle", 32'(mosi), 32'd0);

        // Back-to-back with tx_valid held high
        clear_stats();
        slv_tx   = 8'hC3;
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        wait_rxv("b2b_rx1_wait");
        check("b2b_rx1_data", 32'(rx_data), 32'hC3);
        slv_tx = 8'h7E;
        wait_idle("b2b_gap_wait");
        check("b2b_gap_cs_n", 32'(cs_n), 32'd1);
        @(negedge clk);
        check("b2b_second_accept", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        wait_rxv("b2b_rx2_wait");
        check("b2b_rx2_data", 32'(rx_data), 32'h7E);
        wait_idle("b2b_idle_wait");
        repeat (3) @(negedge clk);
        check("b2b_mosi_bits", 32'(mosi_cap), 32'hFF);
        check("b2b_rises", 32'(rise_cnt), 32'd16);
        check("b2b_rx_pulses", 32'(rxv_cnt), 32'd2);
        check("b2b_frames", 32'(cs_fall_cnt), 32'd2);

        // Reset in the middle of bit 4 of 0x55
        clear_stats();
        slv_tx   = 8'hAA;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 200 && rise_cnt < 4; i++) @(negedge clk);
        if (rise_cnt < 4) timeout("rst_mid_wait");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_sclk", 32'(sclk), 32'd0);
        check("midrst_mosi", 32'(mosi), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (60) @(negedge clk);
        check("midrst_no_rx_valid", 32'(rxv_cnt), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'h00);

        clear_stats();
        slv_tx   = 8'h99;
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rxv("post_rst_rx_wait");
        check("post_rst_rx_data", 32'(rx_data), 32'h99);
        wait_idle("post_rst_idle_wait");
        repeat (3) @(negedge clk);
        check("post_rst_mosi_bits", 32'(mosi_cap), 32'h81);
        check("post_rst_rx_pulses", 32'(rxv_cnt), 32'd1);
        check("post_rst_cs_low", 32'(cs_low), 32'd68);

        // Idle for 100 cycles
        idle_ok_sclk = 0;
        idle_ok_cs   = 0;
        idle_ok_mosi = 0;
        idle_ok_rdy  = 0;
        idle_ok_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sclk === 1'b0) idle_ok_sclk++;
            if (cs_n === 1'b1) idle_ok_cs++;
            if (mosi === 1'b0) idle_ok_mosi++;
            if (tx_ready === 1'b1) idle_ok_rdy++;
            if (busy === 1'b0) idle_ok_busy++;
        end
        check("idle_sclk_low", 32'(idle_ok_sclk), 32'd100);
        check("idle_cs_n_high", 32'(idle_ok_cs), 32'd100);
        check("idle_mosi_low", 32'(idle_ok_mosi), 32'd100);
        check("idle_tx_ready", 32'(idle_ok_rdy), 32'd100);
        check("idle_not_busy", 32'(idle_ok_busy), 32'd100);

`ifdef SPI_MASTER_BURST_EN
        // Two-byte burst under one chip-select window
        clear_stats();
        slv_tx   = 8'h5A;
        tx_data  = 8'h11;
        tx_last  = 1'b0;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h22;
        tx_last = 1'b1;
        wait_rxv("burst_rx1_wait");
        check("burst_rx1_data", 32'(rx_data), 32'h5A);
        for (int i = 0; i < 20 && !tx_ready; i++) @(negedge clk);
        check("burst_cs_kept_low", 32'(cs_n), 32'd0);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rxv("burst_rx2_wait");
        wait_idle("burst_idle_wait");
        repeat (3) @(negedge clk);
        check("burst_frames", 32'(cs_fall_cnt), 32'd1);
        check("burst_rises", 32'(rise_cnt), 32'd16);
        check("burst_rx_pulses", 32'(rxv_cnt), 32'd2);
        check("burst_mosi_bits", 32'(mosi_cap), 32'h22);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
